// File: rtl/mem_access_unit.sv
// mem_access_unit: arbitrates load and store buffer channels onto a single
// data-memory port and broadcasts load results on the common data bus.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_ld_valid/o_ld_ready        per-channel load request / accept
//   i_ld_addr, i_ld_tag          flattened per-channel load address / tag
//   i_st_valid/o_st_ready        per-channel store request / accept
//   i_st_addr, i_st_data         flattened per-channel store address / data
//   o_mem_we/o_mem_addr/o_mem_wdata  memory port (read data one cycle later)
//   i_mem_rdata                  memory read data
//   o_cdb_req/i_cdb_grant        result-bus request / grant
//   o_cdb_tag/o_cdb_data         load result broadcast
module mem_access_unit #(
  parameter int unsigned NUM_LD     = 2,
  parameter int unsigned NUM_ST     = 2,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_LD-1:0]       i_ld_valid,
  output logic [NUM_LD-1:0]       o_ld_ready,
  input  logic [NUM_LD*XLEN-1:0]  i_ld_addr,
  input  logic [NUM_LD*TAG_W-1:0] i_ld_tag,
  input  logic [NUM_ST-1:0]       i_st_valid,
  output logic [NUM_ST-1:0]       o_st_ready,
  input  logic [NUM_ST*XLEN-1:0]  i_st_addr,
  input  logic [NUM_ST*XLEN-1:0]  i_st_data,
  output logic                    o_mem_we,
  output logic [XLEN-1:0]         o_mem_addr,
  output logic [XLEN-1:0]         o_mem_wdata,
  input  logic [XLEN-1:0]         i_mem_rdata,
  output logic                    o_cdb_req,
  input  logic                    i_cdb_grant,
  output logic [TAG_W-1:0]        o_cdb_tag,
  output logic [XLEN-1:0]         o_cdb_data
);

  localparam int unsigned LD_IW = (NUM_LD > 1) ? $clog2(NUM_LD) : 1;
  localparam int unsigned ST_IW = (NUM_ST > 1) ? $clog2(NUM_ST) : 1;
  localparam int unsigned CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_LD_WAIT  = 2'd1;
  localparam logic [1:0] S_LD_BCAST = 2'd2;

  logic [1:0]       r_state;
  logic [LD_IW-1:0] r_ld_ptr;
  logic [ST_IW-1:0] r_st_ptr;
  logic [CNT_W-1:0] r_starve;
  logic [TAG_W-1:0] r_tag;
  logic [XLEN-1:0]  r_data;

  logic [1:0]       w_state_nxt;
  logic [LD_IW-1:0] w_ld_ptr_nxt;
  logic [ST_IW-1:0] w_st_ptr_nxt;
  logic [CNT_W-1:0] w_starve_nxt;
  logic [TAG_W-1:0] w_tag_nxt;
  logic [XLEN-1:0]  w_data_nxt;

  logic             w_ld_any;
  logic [LD_IW-1:0] w_ld_sel;
  logic [XLEN-1:0]  w_ld_addr;
  logic [TAG_W-1:0] w_ld_tag;
  logic             w_st_any;
  logic [ST_IW-1:0] w_st_sel;
  logic [XLEN-1:0]  w_st_addr;
  logic [XLEN-1:0]  w_st_data;

  // Load round-robin: first valid channel at or after the pointer.
  always_comb begin
    logic [LD_IW-1:0] idx;
    w_ld_any  = 1'b0;
    w_ld_sel  = '0;
    w_ld_addr = '0;
    w_ld_tag  = '0;
    idx       = '0;
    for (int i = 0; i < int'(NUM_LD); i++) begin
      idx = LD_IW'((int'(r_ld_ptr) + i) % int'(NUM_LD));
      if (!w_ld_any && i_ld_valid[idx]) begin
        w_ld_any = 1'b1;
        w_ld_sel = idx;
      end
    end
    for (int i = 0; i < int'(NUM_LD); i++) begin
      if (LD_IW'(i) == w_ld_sel) begin
        w_ld_addr = i_ld_addr[i*XLEN +: XLEN];
        w_ld_tag  = i_ld_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  // Store round-robin, independent pointer.
  always_comb begin
    logic [ST_IW-1:0] idx;
    w_st_any  = 1'b0;
    w_st_sel  = '0;
    w_st_addr = '0;
    w_st_data = '0;
    idx       = '0;
    for (int i = 0; i < int'(NUM_ST); i++) begin
      idx = ST_IW'((int'(r_st_ptr) + i) % int'(NUM_ST));
      if (!w_st_any && i_st_valid[idx]) begin
        w_st_any = 1'b1;
        w_st_sel = idx;
      end
    end
    for (int i = 0; i < int'(NUM_ST); i++) begin
      if (ST_IW'(i) == w_st_sel) begin
        w_st_addr = i_st_addr[i*XLEN +: XLEN];
        w_st_data = i_st_data[i*XLEN +: XLEN];
      end
    end
  end

  // Next-state and memory-port decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_ld_ptr_nxt = r_ld_ptr;
    w_st_ptr_nxt = r_st_ptr;
    w_starve_nxt = r_starve;
    w_tag_nxt    = r_tag;
    w_data_nxt   = r_data;
    o_ld_ready   = '0;
    o_st_ready   = '0;
    o_mem_we     = 1'b0;
    o_mem_addr   = '0;
    o_mem_wdata  = '0;

    case (r_state)
      S_IDLE: begin
        // A starved store pre-empts loads; otherwise stores only fill load-free cycles.
        if (w_st_any && ((r_starve == CNT_W'(STARVE_MAX)) || !w_ld_any)) begin
          o_st_ready[w_st_sel] = 1'b1;
          o_mem_we             = 1'b1;
          o_mem_addr           = w_st_addr;
          o_mem_wdata          = w_st_data;
          w_st_ptr_nxt = (w_st_sel == ST_IW'(NUM_ST - 1)) ? '0 : w_st_sel + ST_IW'(1);
          w_starve_nxt = '0;
        end else if (w_ld_any) begin
          o_ld_ready[w_ld_sel] = 1'b1;
          o_mem_addr           = w_ld_addr;
          w_tag_nxt            = w_ld_tag;
          w_ld_ptr_nxt = (w_ld_sel == LD_IW'(NUM_LD - 1)) ? '0 : w_ld_sel + LD_IW'(1);
          // Counter is below the limit here whenever a store is pending.
          if (w_st_any) begin
            w_starve_nxt = r_starve + CNT_W'(1);
          end
          w_state_nxt = S_LD_WAIT;
        end
      end
      S_LD_WAIT: begin
        w_data_nxt  = i_mem_rdata;
        w_state_nxt = S_LD_BCAST;
      end
      S_LD_BCAST: begin
        if (i_cdb_grant) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Reset outranks any request in the same cycle.
    if (i_rst) begin
      o_ld_ready  = '0;
      o_st_ready  = '0;
      o_mem_we    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_ld_ptr <= '0;
      r_st_ptr <= '0;
      r_starve <= '0;
      r_tag    <= '0;
      r_data   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ld_ptr <= w_ld_ptr_nxt;
      r_st_ptr <= w_st_ptr_nxt;
      r_starve <= w_starve_nxt;
      r_tag    <= w_tag_nxt;
      r_data   <= w_data_nxt;
    end
  end

  assign o_cdb_req  = (r_state == S_LD_BCAST);
  assign o_cdb_tag  = r_tag;
  assign o_cdb_data = r_data;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized and directed stimulus for mem_access_unit,
// transaction-level reference model with scoreboard queues for CDB results
// and memory writes.
module tb_mem_access_unit;

  localparam int unsigned NUM_LD     = 2;
  localparam int unsigned NUM_ST     = 2;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned TAG_W      = 4;
  localparam int unsigned STARVE_MAX = 4;

  logic                    clk;
  logic                    i_rst;
  logic [NUM_LD-1:0]       i_ld_valid;
  logic [NUM_LD-1:0]       o_ld_ready;
  logic [NUM_LD*XLEN-1:0]  i_ld_addr;
  logic [NUM_LD*TAG_W-1:0] i_ld_tag;
  logic [NUM_ST-1:0]       i_st_valid;
  logic [NUM_ST-1:0]       o_st_ready;
  logic [NUM_ST*XLEN-1:0]  i_st_addr;
  logic [NUM_ST*XLEN-1:0]  i_st_data;
  logic                    o_mem_we;
  logic [XLEN-1:0]         o_mem_addr;
  logic [XLEN-1:0]         o_mem_wdata;
  logic [XLEN-1:0]         i_mem_rdata;
  logic                    o_cdb_req;
  logic                    i_cdb_grant;
  logic [TAG_W-1:0]        o_cdb_tag;
  logic [XLEN-1:0]         o_cdb_data;

  mem_access_unit #(
    .NUM_LD(NUM_LD), .NUM_ST(NUM_ST), .XLEN(XLEN), .TAG_W(TAG_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready), .i_ld_addr(i_ld_addr), .i_ld_tag(i_ld_tag),
    .i_st_valid(i_st_valid), .o_st_ready(o_st_ready), .i_st_addr(i_st_addr), .i_st_data(i_st_data),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
    .o_cdb_req(o_cdb_req), .i_cdb_grant(i_cdb_grant), .o_cdb_tag(o_cdb_tag), .o_cdb_data(o_cdb_data)
  );

  typedef struct { logic [TAG_W-1:0] tag; logic [XLEN-1:0] data; } cdb_exp_t;
  typedef struct { logic [XLEN-1:0] addr; logic [XLEN-1:0] data; } st_exp_t;

  cdb_exp_t cdb_q[$];
  st_exp_t  st_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: arbitration pointers, starvation count, in-flight load.
  int m_ld_ptr, m_st_ptr, m_starve, m_age;
  bit m_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] mem_fn(input logic [XLEN-1:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0001;
  endfunction

  // Memory device: read data only meaningful one cycle after a load address.
  always @(posedge clk) begin
    if (!i_rst && (o_ld_ready != '0))
      i_mem_rdata <= mem_fn(o_mem_addr);
    else
      i_mem_rdata <= XLEN'($urandom);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ld_ptr = 0; m_st_ptr = 0; m_starve = 0; m_age = 0; m_busy = 1'b0;
    cdb_q.delete();
  endtask

  // One clock cycle: drive inputs, predict the DUT's response, check it.
  task automatic cycle(input bit rst, input logic [NUM_LD-1:0] ldv,
                       input logic [NUM_ST-1:0] stv, input bit gnt);
    logic [NUM_LD-1:0] e_ldr;
    logic [NUM_ST-1:0] e_str;
    logic              e_we, e_req;
    logic [XLEN-1:0]   e_addr, e_wdata, a;
    int lc, sc, c;
    @(negedge clk);
    i_rst = rst; i_ld_valid = ldv; i_st_valid = stv; i_cdb_grant = gnt;
    for (int i = 0; i < int'(NUM_LD); i++) begin
      i_ld_addr[i*XLEN +: XLEN] = XLEN'($urandom);
      i_ld_tag[i*TAG_W +: TAG_W] = TAG_W'($urandom);
    end
    for (int i = 0; i < int'(NUM_ST); i++) begin
      i_st_addr[i*XLEN +: XLEN] = XLEN'($urandom);
      i_st_data[i*XLEN +: XLEN] = XLEN'($urandom);
    end
    #1;
    e_ldr = '0; e_str = '0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
    e_req = m_busy && (m_age >= 2);
    check("cdb_req", 64'(o_cdb_req), 64'(e_req));
    if (e_req && cdb_q.size() > 0) check("cdb_tag_hold", 64'(o_cdb_tag), 64'(cdb_q[0].tag));

    if (rst) begin
      model_reset();
    end else if (m_busy) begin
      if (e_req && gnt) m_busy = 1'b0;
      else m_age++;
    end else begin
      lc = -1; sc = -1;
      for (int k = 0; k < int'(NUM_LD); k++) begin
        c = (m_ld_ptr + k) % int'(NUM_LD);
        if (lc < 0 && ldv[c]) lc = c;
      end
      for (int k = 0; k < int'(NUM_ST); k++) begin
        c = (m_st_ptr + k) % int'(NUM_ST);
        if (sc < 0 && stv[c]) sc = c;
      end
      if (sc >= 0 && (m_starve == int'(STARVE_MAX) || lc < 0)) begin
        e_str[sc] = 1'b1; e_we = 1'b1;
        e_addr  = i_st_addr[sc*XLEN +: XLEN];
        e_wdata = i_st_data[sc*XLEN +: XLEN];
        st_q.push_back('{addr: e_addr, data: e_wdata});
        m_st_ptr = (sc + 1) % int'(NUM_ST);
        m_starve = 0;
      end else if (lc >= 0) begin
        e_ldr[lc] = 1'b1;
        a = i_ld_addr[lc*XLEN +: XLEN];
        e_addr = a;
        cdb_q.push_back('{tag: i_ld_tag[lc*TAG_W +: TAG_W], data: mem_fn(a)});
        m_ld_ptr = (lc + 1) % int'(NUM_LD);
        if (sc >= 0 && m_starve < int'(STARVE_MAX)) m_starve++;
        m_busy = 1'b1; m_age = 1;
      end
    end
    check("ld_ready", 64'(o_ld_ready), 64'(e_ldr));
    check("st_ready", 64'(o_st_ready), 64'(e_str));
    check("mem_we", 64'(o_mem_we), 64'(e_we));
    check("mem_addr", 64'(o_mem_addr), 64'(e_addr));
    check("mem_wdata", 64'(o_mem_wdata), 64'(e_wdata));
  endtask

  // Monitor: pops expected results whenever the DUT completes a broadcast or write.
  initial begin
    cdb_exp_t ce;
    st_exp_t  se;
    forever begin
      @(negedge clk);
      #2;
      if (o_cdb_req && i_cdb_grant && !i_rst) begin
        if (cdb_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL cdb_unexpected: got tag 0x%0h with no load outstanding", o_cdb_tag);
        end else begin
          ce = cdb_q.pop_front();
          check("cdb_tag", 64'(o_cdb_tag), 64'(ce.tag));
          check("cdb_data", 64'(o_cdb_data), 64'(ce.data));
        end
      end
      if (o_mem_we) begin
        if (st_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL st_unexpected: got write addr 0x%0h", o_mem_addr);
        end else begin
          se = st_q.pop_front();
          check("st_addr", 64'(o_mem_addr), 64'(se.addr));
          check("st_data", 64'(o_mem_wdata), 64'(se.data));
        end
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    i_rst = 1'b1; i_ld_valid = '0; i_st_valid = '0; i_cdb_grant = 1'b0;
    i_ld_addr = '0; i_ld_tag = '0; i_st_addr = '0; i_st_data = '0; i_mem_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset state
    cycle(1'b1, '1, '1, 1'b1);
    cycle(1'b1, '0, '0, 1'b0);
    @(posedge clk); #1;
    check("rst_cdb_req", 64'(o_cdb_req), 64'd0);
    check("rst_cdb_tag", 64'(o_cdb_tag), 64'd0);
    check("rst_cdb_data", 64'(o_cdb_data), 64'd0);

    // Two loads back to back with grant held
    for (int i = 0; i < 8; i++) cycle(1'b0, 2'b11, 2'b00, 1'b1);
    drain();

    // Two stores, no loads: consecutive writes ch0 then ch1
    cycle(1'b0, 2'b00, 2'b11, 1'b0);
    cycle(1'b0, 2'b00, 2'b11, 1'b0);
    drain();

    // Starvation: store 0 pending under continuous loads
    for (int i = 0; i < 24; i++) cycle(1'b0, 2'b11, 2'b01, 1'b1);
    drain();

    // Withheld grant: request and tag held, no accepts
    cycle(1'b0, 2'b01, 2'b00, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 2'b11, 2'b11, 1'b0);
    drain();

    // Reset in broadcast state discards the load
    cycle(1'b0, 2'b10, 2'b00, 1'b0);
    cycle(1'b0, 2'b00, 2'b00, 1'b0);
    cycle(1'b0, 2'b00, 2'b00, 1'b0);
    cycle(1'b1, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 2'b00, 2'b00, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      cycle(1'b0, NUM_LD'($urandom), NUM_ST'($urandom), $urandom_range(0, 3) != 0);
    drain();

    check("cdb_q_empty", 64'(cdb_q.size()), 64'd0);
    check("st_q_empty", 64'(st_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
